// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and fetch sequencer in front of the 8-bit ALU.
// It runs IDLE -> RUN -> HALT under the Start/Done handshake. Taken branches
// are resolved through a loadable branch-target table. A saturating counter
// tracks the number of retired instructions.
// Optional build macro PC_RELATIVE_BRANCH_EN: table entries are treated as signed
// PC-relative offsets instead of absolute targets.
`timescale 1ns/1ps
module pc_fetch_ctrl #(
  parameter int PC_W  = 10,
  parameter int LUT_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic             AZero,
  input  logic [LUT_W-1:0] TargetIdx,
  input  logic             HaltReq,
  input  logic             LutWe,
  input  logic [LUT_W-1:0] LutAddr,
  input  logic [PC_W-1:0]  LutData,
  output logic [PC_W-1:0]  PC,
  output logic             FetchValid,
  output logic             BranchTaken,
  output logic             Done,
  output logic [CNT_W-1:0] InstCount
);

  localparam int LUT_N = 1 << LUT_W;
  localparam logic [PC_W-1:0]  PC_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic              start_q;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bt_q, bt_d;
  logic              done_q;
  logic              lut_we;
  logic [PC_W-1:0]   lut_q [LUT_N];
  logic [PC_W-1:0]   branch_pc;
  logic [CNT_W-1:0]  cnt_inc;

  wire start_fall = start_q & ~Start;
  wire start_rise = ~start_q & Start;

  // Branch destination: absolute table entry, or PC plus a signed table offset.
`ifdef PC_RELATIVE_BRANCH_EN
  assign branch_pc = pc_q + lut_q[TargetIdx];
`else
  assign branch_pc = lut_q[TargetIdx];
`endif

  // The retired-instruction counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

  // Next-state, next-PC and next-count selection.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    bt_d    = 1'b0;
    lut_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_d   = '0;
        cnt_d  = '0;
        lut_we = LutWe;
        if (start_fall) state_d = S_RUN;
      end
      S_RUN: begin
        // A stalled cycle freezes everything; BranchTaken falls through to 0.
        if (!Stall) begin
          cnt_d = cnt_inc;
          if (HaltReq) begin
            state_d = S_HALT;
          end else if (BranchEn && AZero) begin
            pc_d = branch_pc;
            bt_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end
      S_HALT: begin
        if (start_rise) begin
          state_d = S_IDLE;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Control registers; Done mirrors the state being entered.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      pc_q    <= '0;
      cnt_q   <= '0;
      bt_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= Start;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      bt_q    <= bt_d;
      done_q  <= (state_d == S_HALT);
    end
  end

  // Branch-target table; it is writable only in IDLE.
  always_ff @(posedge Clk or posedge Reset) begin
    // NOTE: this table is cleared by reset, so it has to be built from flops rather than a RAM macro.
    if (Reset) begin
      for (int i = 0; i < LUT_N; i++) lut_q[i] <= '0;
    end else if (lut_we) begin
      lut_q[LutAddr] <= LutData;
    end
  end

  assign PC          = pc_q;
  assign FetchValid  = (state_q == S_RUN) && !Stall;
  assign BranchTaken = bt_q;
  assign Done        = done_q;
  assign InstCount   = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Testbench for pc_fetch_ctrl. It runs directed scenarios first and then a
// randomized phase. A behavioural model is compared with the DUT on every cycle.
// A second, narrow instance covers PC wrap-around and counter saturation.
`timescale 1ns/1ps
module tb_pc_fetch_ctrl;
  localparam int PC_W  = 10;
  localparam int LUT_W = 4;
  localparam int CNT_W = 16;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             Start = 1'b0, Stall = 1'b0, BranchEn = 1'b0, AZero = 1'b0;
  logic [LUT_W-1:0] TargetIdx = '0;
  logic             HaltReq = 1'b0, LutWe = 1'b0;
  logic [LUT_W-1:0] LutAddr = '0;
  logic [PC_W-1:0]  LutData = '0;
  logic [PC_W-1:0]  PC;
  logic             FetchValid, BranchTaken, Done;
  logic [CNT_W-1:0] InstCount;

  // Narrow instance signals.
  logic       s_start = 1'b0;
  logic [3:0] s_pc;
  logic       s_fv, s_bt, s_done;
  logic [2:0] s_cnt;

  always #5 Clk = ~Clk;

  pc_fetch_ctrl #(.PC_W(PC_W), .LUT_W(LUT_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .BranchEn(BranchEn),
    .AZero(AZero), .TargetIdx(TargetIdx), .HaltReq(HaltReq), .LutWe(LutWe),
    .LutAddr(LutAddr), .LutData(LutData), .PC(PC), .FetchValid(FetchValid),
    .BranchTaken(BranchTaken), .Done(Done), .InstCount(InstCount)
  );

  pc_fetch_ctrl #(.PC_W(4), .LUT_W(2), .CNT_W(3)) dut_small (
    .Clk(Clk), .Reset(Reset), .Start(s_start), .Stall(1'b0), .BranchEn(1'b0),
    .AZero(1'b0), .TargetIdx(2'd0), .HaltReq(1'b0), .LutWe(1'b0),
    .LutAddr(2'd0), .LutData(4'd0), .PC(s_pc), .FetchValid(s_fv),
    .BranchTaken(s_bt), .Done(s_done), .InstCount(s_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=idle, 1=running, 2=halted.
  int m_mode, m_next, m_pc, m_cnt, m_bt, m_done, m_prev_start;
  int m_lut [1 << LUT_W];

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_bt = 0; m_done = 0; m_prev_start = 0;
      for (int i = 0; i < (1 << LUT_W); i++) m_lut[i] = 0;
    end else begin
      m_next = m_mode;
      m_bt = 0;
      if (m_mode == 0) begin
        m_pc = 0; m_cnt = 0;
        if (LutWe) m_lut[LutAddr] = int'(LutData);
        if (m_prev_start == 1 && !Start) m_next = 1;
      end else if (m_mode == 1) begin
        if (!Stall) begin
          if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
          if (HaltReq) m_next = 2;
          else if (BranchEn && AZero) begin
`ifdef PC_RELATIVE_BRANCH_EN
            m_pc = (m_pc + m_lut[TargetIdx]) % PC_MOD;
`else
            m_pc = m_lut[TargetIdx];
`endif
            m_bt = 1;
          end else m_pc = (m_pc + 1) % PC_MOD;
        end
      end else begin
        if (m_prev_start == 0 && Start) begin
          m_next = 0; m_pc = 0; m_cnt = 0;
        end
      end
      m_mode = m_next;
      m_done = (m_next == 2) ? 1 : 0;
      m_prev_start = Start ? 1 : 0;
    end
  end

  // Cycle compare: DUT against the model, 2 ns after every rising edge.
  initial begin
    forever begin
      @(posedge Clk);
      #2;
      if (!Reset) begin
        check("model_pc", 32'(PC), 32'(m_pc));
        check("model_fetch_valid", 32'(FetchValid), 32'((m_mode == 1 && !Stall) ? 1 : 0));
        check("model_branch_taken", 32'(BranchTaken), 32'(m_bt));
        check("model_done", 32'(Done), 32'(m_done));
        check("model_inst_count", 32'(InstCount), 32'(m_cnt));
      end
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input int addr, input int data);
    LutWe = 1'b1; LutAddr = LUT_W'(addr); LutData = PC_W'(data);
    cyc();
    LutWe = 1'b0;
  endtask

  task automatic br(input int idx, input logic az);
    BranchEn = 1'b1; AZero = az; TargetIdx = LUT_W'(idx);
    cyc();
    BranchEn = 1'b0; AZero = 1'b0;
  endtask

  task automatic launch();
    Start = 1'b1;
    repeat (3) cyc();
    Start = 1'b0;
    cyc();
  endtask

  initial begin
    #1 Reset = 1'b1;
    #12;
    check("reset_pc", 32'(PC), 32'h0);
    check("reset_done", 32'(Done), 32'h0);
    check("reset_count", 32'(InstCount), 32'h0);
    check("reset_fv_bt", 32'({FetchValid, BranchTaken}), 32'h0);
    #2 Reset = 1'b0;

    // Narrow instance: wrap at 15 and saturation at 7.
    s_start = 1'b1;
    repeat (2) cyc();
    s_start = 1'b0;
    cyc();
    check("small_launch_pc", 32'(s_pc), 32'h0);
    check("small_launch_fv", 32'(s_fv), 32'h1);
    for (int k = 1; k <= 20; k++) begin
      cyc();
      check("small_wrap_pc", 32'(s_pc), 32'(k % 16));
      check("small_sat_cnt", 32'(s_cnt), 32'((k < 7) ? k : 7));
    end

`ifdef PC_RELATIVE_BRANCH_EN
    load(2, 'h3FD);
    load(3, 5);
    load(4, 'h3F1);
    launch();
    repeat (16) cyc();
    check("rel_pc_10", 32'(PC), 32'h010);
    br(2, 1'b1);
    check("rel_back3", 32'(PC), 32'h00D);
    br(4, 1'b1);
    check("rel_to_3fe", 32'(PC), 32'h3FE);
    br(3, 1'b1);
    check("rel_fwd_wrap", 32'(PC), 32'h003);
`else
    // Table load and launch.
    load(5, 'h120);
    load(3, 7);
    load(4, 'h20);
    check("idle_pc", 32'(PC), 32'h0);
    Start = 1'b1;
    repeat (3) begin
      cyc();
      check("idle_pc_start_high", 32'(PC), 32'h0);
      check("idle_fv", 32'(FetchValid), 32'h0);
    end
    Start = 1'b0;
    cyc();
    check("launch_pc0", 32'(PC), 32'h0);
    check("launch_fv", 32'(FetchValid), 32'h1);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      check("seq_pc", 32'(PC), 32'(k));
    end
    br(5, 1'b1);
    check("taken_pc", 32'(PC), 32'h120);
    check("taken_bt", 32'(BranchTaken), 32'h1);
    cyc();
    check("after_taken_pc", 32'(PC), 32'h121);
    check("bt_one_cycle", 32'(BranchTaken), 32'h0);
    br(3, 1'b1);
    check("back_to_7", 32'(PC), 32'h7);
    br(5, 1'b0);
    check("not_taken_pc", 32'(PC), 32'h8);
    check("not_taken_bt", 32'(BranchTaken), 32'h0);
    br(4, 1'b1);
    check("pc_0x20", 32'(PC), 32'h20);
    check("count_12", 32'(InstCount), 32'd12);

    // Stall takes priority over halt and branch.
    Stall = 1'b1; HaltReq = 1'b1; BranchEn = 1'b1; AZero = 1'b1; TargetIdx = 4'd5;
    repeat (2) begin
      cyc();
      check("stall_pc", 32'(PC), 32'h20);
      check("stall_done", 32'(Done), 32'h0);
      check("stall_fv", 32'(FetchValid), 32'h0);
      check("stall_count", 32'(InstCount), 32'd12);
    end
    Stall = 1'b0;
    cyc();
    check("halt_done", 32'(Done), 32'h1);
    check("halt_pc", 32'(PC), 32'h20);
    check("halt_count", 32'(InstCount), 32'd13);
    check("halt_no_branch", 32'(BranchTaken), 32'h0);
    HaltReq = 1'b0; BranchEn = 1'b0; AZero = 1'b0;
    repeat (2) cyc();
    check("halt_frozen_count", 32'(InstCount), 32'd13);
    check("halt_frozen_pc", 32'(PC), 32'h20);
    Start = 1'b1;
    cyc();
    check("rehome_done", 32'(Done), 32'h0);
    check("rehome_pc", 32'(PC), 32'h0);
    check("rehome_count", 32'(InstCount), 32'h0);

    // Mid-run reset and table write protection.
    load(1, 'h10);
    load(2, 'h55);
    Start = 1'b0;
    cyc();
    check("relaunch_fv", 32'(FetchValid), 32'h1);
    LutWe = 1'b1; LutAddr = 4'd1; LutData = 10'h33;
    cyc();
    LutWe = 1'b0;
    br(1, 1'b1);
    check("run_write_ignored", 32'(PC), 32'h10);
    br(2, 1'b1);
    check("pc_0x55", 32'(PC), 32'h55);
    #2 Reset = 1'b1;
    #1;
    check("async_reset_pc", 32'(PC), 32'h0);
    check("async_reset_fv", 32'(FetchValid), 32'h0);
    check("async_reset_count", 32'(InstCount), 32'h0);
    #2 Reset = 1'b0;
    launch();
    cyc();
    br(1, 1'b1);
    check("entry1_cleared", 32'(PC), 32'h0);
`endif

    // Randomized phase, checked by the model on every cycle.
    for (int n = 0; n < 3000; n++) begin
      Stall     = ($urandom_range(0, 5) == 0);
      BranchEn  = ($urandom_range(0, 3) == 0);
      AZero     = $urandom_range(0, 1) == 1;
      TargetIdx = LUT_W'($urandom_range(0, (1 << LUT_W) - 1));
      HaltReq   = ($urandom_range(0, 29) == 0);
      LutWe     = ($urandom_range(0, 2) == 0);
      LutAddr   = LUT_W'($urandom_range(0, (1 << LUT_W) - 1));
      LutData   = PC_W'($urandom_range(0, PC_MOD - 1));
      if ($urandom_range(0, 3) == 0) Start = ~Start;
      if ($urandom_range(0, 399) == 0) begin
        #2 Reset = 1'b1;
        #1;
        check("rand_async_reset_pc", 32'(PC), 32'h0);
        check("rand_async_reset_done", 32'(Done), 32'h0);
        #2 Reset = 1'b0;
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch sequencer directly upstream of the 8-bit ALU.
- Generates the instruction-memory address each cycle.
- Consumes the ALU's branch-zero flag (AZero) to take branches through a loadable branch-target lookup table.
- Runs the Start/Done program handshake with the testbench and keeps a saturating executed-instruction counter.

Parameters:
- PC_W, 10, program-counter / instruction-address width.
- LUT_W, 4, branch-target table index width; the table holds 2**LUT_W entries of PC_W bits.
- CNT_W, 16, executed-instruction counter width.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  program start request, level; the program begins on its falling edge.
- Stall  input  1  freeze request; while high, PC, counter and state hold.
- BranchEn  input  1  decoded branch instruction in the current cycle.
- AZero  input  1  ALU flag: operand A is all zero (branch condition).
- TargetIdx  input  LUT_W  branch-table index from the instruction.
- HaltReq  input  1  decoded halt instruction.
- LutWe  input  1  branch-table write enable (IDLE state only).
- LutAddr  input  LUT_W  branch-table write index.
- LutData  input  PC_W  branch-table write data.
- PC  output  PC_W  current instruction address.
- FetchValid  output  1  PC addresses a live instruction (RUN and not Stall).
- BranchTaken  output  1  registered pulse: the previous cycle's branch was taken.
- Done  output  1  program finished (HALT state).
- InstCount  output  CNT_W  instructions retired since the program started.

Behaviour:
- Reset (async, any time, including mid-run) forces state IDLE and zeroes every output: PC=0, FetchValid=0, BranchTaken=0, Done=0, InstCount=0. All branch-table entries clear to 0.
- States: IDLE, RUN, HALT. They are encoded in 2 bits; the unused encoding returns to IDLE on the next edge.
- IDLE:
  - PC held at 0; InstCount held at 0.
  - Table writes accepted: when LutWe=1, entry[LutAddr] <= LutData at the edge.
  - Exit to RUN at the first edge where Start=0 and Start was 1 on the previous edge (registered edge detect). Start held low from reset does not launch.
- RUN, with Stall=1: nothing updates; FetchValid=0; BranchTaken cleared.
- RUN, with Stall=0, rules in priority order:
  1. HaltReq=1: go to HALT. PC holds; InstCount increments (the halt counts). Any simultaneous branch is ignored.
  2. BranchEn=1 and AZero=1: PC <= entry[TargetIdx]; BranchTaken=1 next cycle; InstCount increments.
  3. Otherwise PC <= PC+1, modulo 2**PC_W. At the all-ones PC it wraps silently to 0. A not-taken branch also takes this path.
- InstCount saturates at all-ones; it never wraps.
- LutWe is ignored outside IDLE.
- HALT:
  - Done=1; PC and InstCount frozen.
  - A Start rising edge returns to IDLE: Done=0, PC=0, InstCount=0. Table contents are retained.
- Latency:
  - PC changes exactly one edge after the qualifying inputs.
  - Done rises one edge after HaltReq is sampled.
- Stall has priority over HaltReq and over the branch.
- All outputs are registered except FetchValid, which is combinational from state and Stall.

Optional Feature:
- Macro: PC_RELATIVE_BRANCH_EN.
- Defined: table entries are signed two's-complement PC_W-bit offsets; a taken branch sets PC <= PC + entry[TargetIdx], modulo 2**PC_W. A zero entry therefore spins on the same instruction.
- Undefined: entries are absolute targets as described above.
- Default: undefined.

Test Plan:
- Launch: Reset pulse, then Start=1 for 3 cycles, then 0. PC=0 through IDLE, RUN entered one edge after the fall, then PC=1,2,3 on successive edges; FetchValid=1.
- Taken branch: load entry[5]=0x120 in IDLE; in RUN at PC=7 drive BranchEn=1, AZero=1, TargetIdx=5. Next PC=0x120, BranchTaken=1 for exactly one cycle. Repeat with AZero=0: next PC=8, BranchTaken=0.
- Halt priority and stall: at PC=0x20 drive Stall=1, HaltReq=1 for 2 cycles, then Stall=0. PC stays 0x20, Done=0 while stalled, then Done=1 one edge after release; InstCount then frozen.
- Wrap and saturation: run with PC_W=4, CNT_W=3 and no branches for 20 cycles. PC goes 15→0; InstCount sticks at 7.
- Reset mid-run: assert Reset asynchronously (between edges) at PC=0x55 with entry[1]=0x10. PC=0, state IDLE and entry[1]=0 immediately, without waiting for a clock edge. A LutWe during RUN leaves the table unchanged.
- PC_RELATIVE_BRANCH_EN build: entry[2]=-3 (0x3FD), branch taken at PC=0x010. Next PC=0x00D; entry=+5 at PC=0x3FE gives PC=0x003.
